// File: rtl/inter_slave_if.sv
// inter_slave_if: valid/ready write-beat bus between interconnect and slave.
// Signals: valid, addr[2:0], value[2:0] (master->slave), ready (slave->master).
interface inter_slave_if;
  logic       valid;
  logic [2:0] addr;
  logic [2:0] value;
  logic       ready;

  modport master (
    output valid,
    output addr,
    output value,
    input  ready
  );

  modport slave (
    input  valid,
    input  addr,
    input  value,
    output ready
  );
endinterface

// File: rtl/inter_slave.sv
// inter_slave: wait-state slave responder committing beats into an 8x3 regfile.
// Ports: clk, rst_n, bus (valid/addr/value/ready), rd_addr/rd_data, wr_done, xfer_cnt.
// Build option INTER_SLAVE_ACCUM_EN: commits add value into the entry (mod 8).
module inter_slave #(
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  inter_slave_if.slave bus,
  input  logic [2:0]   rd_addr,
  output logic [2:0]   rd_data,
  output logic         wr_done,
  output logic [7:0]   xfer_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RDY  = 2'd2;

  localparam logic [2:0] CNT_INIT =
    (WAIT_CYC == 0) ? 3'd0 : 3'(WAIT_CYC - 1);

  logic [1:0] state;
  logic [2:0] cnt;
  logic       rdy_q;
  logic       commit;
  logic [2:0] wr_val;
  logic [2:0] mem [8];

  assign bus.ready = rdy_q;

  // ready is only ever high in RDY, so this is the handshake edge
  assign commit = (state == S_RDY) && bus.valid && rdy_q;

`ifdef INTER_SLAVE_ACCUM_EN
  assign wr_val = mem[bus.addr] + bus.value;
`else
  assign wr_val = bus.value;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 3'd0;
      rdy_q    <= 1'b0;
      wr_done  <= 1'b0;
      xfer_cnt <= 8'd0;
    end else begin
      wr_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          rdy_q <= 1'b0;
          if (bus.valid) begin
            if (WAIT_CYC == 0) begin
              state <= S_RDY;
              rdy_q <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.valid) begin
            state <= S_IDLE;
          end else if (cnt == 3'd0) begin
            state <= S_RDY;
            rdy_q <= 1'b1;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RDY: begin
          // a beat still held high must restart the wait sequence
          state <= S_IDLE;
          rdy_q <= 1'b0;
          if (commit) begin
            wr_done  <= 1'b1;
            xfer_cnt <= xfer_cnt + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          rdy_q <= 1'b0;
        end
      endcase
    end
  end

  // read uses pre-edge contents: same-edge write shows up next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        mem[i] <= 3'd0;
      end
    end else begin
      rd_data <= mem[rd_addr];
      if (commit) begin
        mem[bus.addr] <= wr_val;
      end
    end
  end

endmodule

// File: tb/tb_inter_slave.sv
// tb_inter_slave: self-checking bench, three instances (WAIT_CYC 2, 0, 3).
// Scoreboard tracks expected xfer_cnt per committed beat; tables check regfile.
module tb_inter_slave;

  localparam int WC [3] = '{2, 0, 3};

  logic       clk;
  logic       rst_n;
  logic       v_valid   [3];
  logic [2:0] v_addr    [3];
  logic [2:0] v_value   [3];
  logic [2:0] v_rd_addr [3];
  logic       o_ready   [3];
  logic [2:0] o_rd      [3];
  logic       o_wr_done [3];
  logic [7:0] o_xfer    [3];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int cnt_m [3];

  typedef struct {
    int inst;
    int cnt;
  } sb_t;
  sb_t sb_q [$];

  typedef struct {
    logic [2:0] a;
    logic [2:0] v;
    logic [2:0] exp;
  } vec_t;
  vec_t tbl [6];

  inter_slave_if b0 ();
  inter_slave_if b1 ();
  inter_slave_if b2 ();

  assign b0.valid = v_valid[0];
  assign b0.addr  = v_addr[0];
  assign b0.value = v_value[0];
  assign o_ready[0] = b0.ready;
  assign b1.valid = v_valid[1];
  assign b1.addr  = v_addr[1];
  assign b1.value = v_value[1];
  assign o_ready[1] = b1.ready;
  assign b2.valid = v_valid[2];
  assign b2.addr  = v_addr[2];
  assign b2.value = v_value[2];
  assign o_ready[2] = b2.ready;

  inter_slave #(.WAIT_CYC(2)) d_w2 (
    .clk(clk), .rst_n(rst_n), .bus(b0),
    .rd_addr(v_rd_addr[0]), .rd_data(o_rd[0]),
    .wr_done(o_wr_done[0]), .xfer_cnt(o_xfer[0])
  );
  inter_slave #(.WAIT_CYC(0)) d_w0 (
    .clk(clk), .rst_n(rst_n), .bus(b1),
    .rd_addr(v_rd_addr[1]), .rd_data(o_rd[1]),
    .wr_done(o_wr_done[1]), .xfer_cnt(o_xfer[1])
  );
  inter_slave #(.WAIT_CYC(3)) d_w3 (
    .clk(clk), .rst_n(rst_n), .bus(b2),
    .rd_addr(v_rd_addr[2]), .rd_data(o_rd[2]),
    .wr_done(o_wr_done[2]), .xfer_cnt(o_xfer[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // scoreboard consumer: every wr_done pulse must match a driven beat
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (o_wr_done[i] === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_spurious: inst %0d got wr_done required none", i);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          check("sb_inst", i, e.inst);
          check("sb_cnt", o_xfer[i], e.cnt);
        end
      end
    end
  end

  // one full beat; returns at the negedge after the handshake edge
  task automatic beat(input int i,
                      input logic [2:0] a,
                      input logic [2:0] v,
                      input bit drop,
                      output int rc);
    int n;
    n = 0;
    v_valid[i] = 1'b1;
    v_addr[i]  = a;
    v_value[i] = v;
    cnt_m[i] = (cnt_m[i] + 1) % 256;
    sb_q.push_back('{i, cnt_m[i]});
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (o_ready[i] !== 1'b1 && n < 20);
    check("ready_lat", n, WC[i] + 1);
    rc = cyc;
    @(posedge clk);
    @(negedge clk);
    check("ready_pulse", o_ready[i], 0);
    if (drop) v_valid[i] = 1'b0;
  endtask

  task automatic rd_chk(input int i,
                        input logic [2:0] a,
                        input logic [2:0] exp,
                        input string name);
    v_rd_addr[i] = a;
    @(posedge clk);
    @(negedge clk);
    check(name, o_rd[i], exp);
  endtask

  initial begin
    int  rc0;
    int  rc1;
    bit  saw;
    int  n;

    tbl[0] = '{3'd5, 3'd3, 3'd3};
    tbl[1] = '{3'd0, 3'd5, 3'd5};
`ifdef INTER_SLAVE_ACCUM_EN
    tbl[2] = '{3'd0, 3'd6, 3'd3};
`else
    tbl[2] = '{3'd0, 3'd6, 3'd6};
`endif
    tbl[3] = '{3'd7, 3'd7, 3'd7};
    tbl[4] = '{3'd3, 3'd1, 3'd1};
`ifdef INTER_SLAVE_ACCUM_EN
    tbl[5] = '{3'd7, 3'd2, 3'd1};
`else
    tbl[5] = '{3'd7, 3'd2, 3'd2};
`endif

    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_valid[i]   = 1'b0;
      v_addr[i]    = 3'd0;
      v_value[i]   = 3'd0;
      v_rd_addr[i] = 3'd0;
      cnt_m[i]     = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_ready", o_ready[i], 0);
      check("rst_wr_done", o_wr_done[i], 0);
      check("rst_xfer", o_xfer[i], 0);
      check("rst_rd", o_rd[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // table of single beats on the WAIT_CYC=2 instance
    for (int k = 0; k < 6; k++) begin
      beat(0, tbl[k].a, tbl[k].v, 1'b1, rc0);
      rd_chk(0, tbl[k].a, tbl[k].exp, "tbl_rd");
    end
    check("tbl_xfer", o_xfer[0], 6);

    // back-to-back with valid held, WAIT_CYC=0
    beat(1, 3'd1, 3'd7, 1'b0, rc0);
    beat(1, 3'd2, 3'd4, 1'b1, rc1);
    check("b2b_spacing", rc1 - rc0, 2);
    check("b2b_xfer", o_xfer[1], 2);
    rd_chk(1, 3'd1, 3'd7, "b2b_rd1");
    rd_chk(1, 3'd2, 3'd4, "b2b_rd2");

    // abort during WAIT, WAIT_CYC=3
    v_valid[2] = 1'b1;
    v_addr[2]  = 3'd6;
    v_value[2] = 3'd5;
    saw = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      saw |= o_ready[2];
    end
    v_valid[2] = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      saw |= o_ready[2];
    end
    check("abort_ready", saw, 0);
    check("abort_xfer", o_xfer[2], 0);
    rd_chk(2, 3'd6, 3'd0, "abort_rd");
    beat(2, 3'd6, 3'd2, 1'b1, rc0);
    rd_chk(2, 3'd6, 3'd2, "w3_rd");

    // same-edge read and write of entry 4
    v_rd_addr[0] = 3'd4;
    beat(0, 3'd4, 3'd6, 1'b1, rc0);
    check("rw_old", o_rd[0], 0);
    @(posedge clk);
    @(negedge clk);
    check("rw_new", o_rd[0], 6);

    // reset while in RDY drops the beat
    v_rd_addr[0] = 3'd5;
    v_valid[0] = 1'b1;
    v_addr[0]  = 3'd2;
    v_value[0] = 3'd5;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (o_ready[0] !== 1'b1 && n < 20);
    check("pre_rst_ready", o_ready[0], 1);
    check("pre_rst_rd", o_rd[0], 3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", o_ready[0], 0);
    check("mid_rst_wr_done", o_wr_done[0], 0);
    check("mid_rst_xfer", o_xfer[0], 0);
    check("mid_rst_rd", o_rd[0], 0);
    check("mid_rst_xfer1", o_xfer[1], 0);
    v_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) cnt_m[i] = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd_chk(0, 3'(a), 3'd0, "post_rst_mem");
    end
    beat(0, 3'd1, 3'd6, 1'b1, rc0);
    rd_chk(0, 3'd1, 3'd6, "post_rst_rd");

    repeat (4) @(negedge clk);
    check("sb_pending", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
